buffer_uart_tx: RTL and testbench
=================================

Name: buffer_uart_tx

Overview:
- Downstream consumer of the 32-bit sample buffer: pops one word whenever the buffer shows valid data.
- Serialises each word as DATA_WIDTH/8 UART frames (8N1, MSB byte first) on a single tx line to the host PC.
- Sits between the buffer output port and the FPGA UART pin; sole reader of the buffer.

Parameters:
- DATA_WIDTH, 32, word width from buffer; must be a multiple of 8.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.
- CNT_W, 10, width of baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- word_in  input  DATA_WIDTH  buffer data_out.
- word_valid  input  1  buffer data_out_valid.
- word_read  output  1  to buffer data_out_read; single-cycle pop pulse.
- tx  output  1  UART line, idle high.
- busy  output  1  high from word capture until last stop bit completes.
- words_sent  output  16  count of fully transmitted words, wraps at 0xFFFF.

Behaviour:
- Reset (rst=0, async): tx=1, word_read=0, busy=0, words_sent=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- States: IDLE, FETCH, GUARD, START, DATA, STOP.
- IDLE: if word_valid=1, latch word_in into shift register, word_read<=1, busy<=1, byte_idx<=0 -> FETCH.
- FETCH (1 cycle): word_read<=0 -> GUARD. word_read is never high two consecutive cycles.
- GUARD (1 cycle): word_valid ignored; it may be stale while the buffer updates. -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
- DATA: tx = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 -> STOP.
- Byte order: byte 0 sent is word[DATA_WIDTH-1 -: 8]. Shift register shifts left by 8 per byte.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx < DATA_WIDTH/8-1: byte_idx+1 -> START, with no idle gap between frames.
  - Otherwise: words_sent+1, busy<=0 -> IDLE.
- Back-to-back words: IDLE samples word_valid on the cycle after STOP ends. Minimum inter-word gap on tx is 3 idle-high cycles (IDLE, FETCH, GUARD).
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads 0 on every state entry. No fractional baud.
- word_in is sampled only in IDLE with word_valid=1. Changes to word_in during transmission have no effect.
- Empty buffer (word_valid=0): block stays in IDLE, tx=1, word_read=0.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits (8E1).
- Undefined: 8N1, 10-bit frames, no PARITY state.

Decomposition:
- Shared package holds:
  - the state enum encoding (3-bit localparams);
  - UART frame constants (START_BIT=0, STOP_BIT=1, BITS_PER_BYTE=8);
  - the DATA_WIDTH default shared with the buffer.
- One natural sub-module: uart_byte_tx. It sends one byte given start/ready and contains START/DATA/(PARITY)/STOP plus the baud counter.
- buffer_uart_tx keeps IDLE/FETCH/GUARD, the word shift register, byte_idx and words_sent.

Test Plan:
1. Reset: hold rst=0 with word_valid=1 -> tx=1, word_read=0, busy=0, words_sent=0 throughout.
2. Single word, CLKS_PER_BIT=4: word_in=0xA1B2C3D4 -> exactly one word_read pulse; bytes decoded on tx are A1,B2,C3,D4 with start 0/stop 1, 40 bits in 160 cycles after START; words_sent=1.
3. Back-to-back: word_valid held high, two words 0x00000000 then 0xFFFFFFFF -> two word_read pulses; gap between last stop of word 1 and first start of word 2 is 3 cycles; words_sent=2.
4. Stale valid: after a word_read pulse, word_valid kept high for one cycle then dropped (buffer empty) -> no second word_read; block returns to IDLE after word 1.
5. Reset mid-frame: assert rst=0 during DATA bit 3 of byte 1 -> tx=1 immediately, state IDLE; after release, a new word transmits correctly from byte 0.
6. With UART_PARITY_EN, word_in=0x07000000 -> first frame carries parity bit 1 (three ones), remaining frames parity 0; 44 bits total.

Source files
------------

// File: rtl/buffer_uart_tx_pkg.sv
// Shared definitions for the buffer-to-UART bridge: state encodings, UART frame constants
// and the word width shared with the sample buffer.
package buffer_uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_GUARD  = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_PARITY = 3'd6;
  localparam logic [2:0] ST_SEND   = 3'd7;

  // Word-level sequencing; W_SEND covers the whole time the byte transmitter is busy.
  typedef enum logic [2:0] {
    W_IDLE  = ST_IDLE,
    W_FETCH = ST_FETCH,
    W_GUARD = ST_GUARD,
    W_SEND  = ST_SEND
  } word_state_e;

  typedef enum logic [2:0] {
    B_IDLE   = ST_IDLE,
    B_START  = ST_START,
    B_DATA   = ST_DATA,
    B_PARITY = ST_PARITY,
    B_STOP   = ST_STOP
  } byte_state_e;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [BITS_PER_BYTE-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/buffer_uart_tx_uart_byte_tx.sv
// Single-byte UART transmitter (8N1, or 8E1 when UART_PARITY_EN is defined).
// A start request on the last stop-bit cycle chains the next frame with no idle gap.
module uart_byte_tx
  import buffer_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BITS_PER_BYTE-1:0] data,
  output logic                     byte_done,
  output logic                     tx
);

  localparam int               BIT_IDX_W = $clog2(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BITS_PER_BYTE - 1);

  byte_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [BITS_PER_BYTE-1:0] data_q, data_d;
  logic                     tx_q, tx_d;
  logic                     last_tick;

  assign last_tick = (cnt_q == LAST_CNT);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    byte_done = 1'b0;

    case (state_q)
      B_IDLE: begin
        if (start) begin
          data_d  = data;
          state_d = B_START;
        end
      end
      B_START: begin
        if (last_tick) begin
          bit_idx_d = '0;
          state_d   = B_DATA;
        end
      end
      B_DATA: begin
        if (last_tick) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_d = B_PARITY;
`else
            state_d = B_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      B_PARITY: begin
        if (last_tick) state_d = B_STOP;
      end
      B_STOP: begin
        if (last_tick) begin
          byte_done = 1'b1;
          if (start) begin
            data_d  = data;
            state_d = B_START;
          end else begin
            state_d = B_IDLE;
          end
        end
      end
      default: state_d = B_IDLE;
    endcase

    // Counter reloads on every state entry and on every bit boundary inside DATA.
    if (state_q == B_IDLE || last_tick) cnt_d = '0;
    else                                cnt_d = cnt_q + 1'b1;

    // Line level is registered from the next state so tx never glitches.
    case (state_d)
      B_START:  tx_d = START_BIT;
      B_DATA:   tx_d = data_d[bit_idx_d];
      B_PARITY: tx_d = even_parity(data_d);
      default:  tx_d = STOP_BIT;
    endcase
  end

  // NOTE: non-blocking assignments make every flop update from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= STOP_BIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/buffer_uart_tx.sv
// Pops words from the sample buffer and sends each as DATA_WIDTH/8 UART frames, MSB byte first.
// Build option: define UART_PARITY_EN for 8E1 frames instead of 8N1.
module buffer_uart_tx
  import buffer_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_read,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int NUM_BYTES  = DATA_WIDTH / BITS_PER_BYTE;
  localparam int BYTE_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NUM_BYTES - 1);

  word_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic                  word_read_q, word_read_d;
  logic                  busy_q, busy_d;
  logic [15:0]           words_sent_q, words_sent_d;

  logic                     byte_start;
  logic                     byte_done;
  logic [BITS_PER_BYTE-1:0] byte_data;

  // The byte transmitter latches the top byte on byte_start, and the word shifts at the same time.
  assign byte_data = shreg_q[DATA_WIDTH-1 -: BITS_PER_BYTE];

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_idx_d   = byte_idx_q;
    word_read_d  = 1'b0;
    busy_d       = busy_q;
    words_sent_d = words_sent_q;
    byte_start   = 1'b0;

    case (state_q)
      W_IDLE: begin
        if (word_valid) begin
          shreg_d     = word_in;
          word_read_d = 1'b1;
          busy_d      = 1'b1;
          byte_idx_d  = '0;
          state_d     = W_FETCH;
        end
      end
      W_FETCH: state_d = W_GUARD;
      // word_valid may still show the popped word here, so it is deliberately not looked at.
      W_GUARD: begin
        byte_start = 1'b1;
        shreg_d    = shreg_q << BITS_PER_BYTE;
        state_d    = W_SEND;
      end
      W_SEND: begin
        if (byte_done) begin
          if (byte_idx_q == LAST_BYTE) begin
            words_sent_d = words_sent_q + 16'd1;
            busy_d       = 1'b0;
            state_d      = W_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            byte_start = 1'b1;
            shreg_d    = shreg_q << BITS_PER_BYTE;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= W_IDLE;
      shreg_q      <= '0;
      byte_idx_q   <= '0;
      word_read_q  <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_idx_q   <= byte_idx_d;
      word_read_q  <= word_read_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (byte_start),
    .data     (byte_data),
    .byte_done(byte_done),
    .tx       (tx)
  );

  assign word_read  = word_read_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Directed bench for buffer_uart_tx at CLKS_PER_BIT=4; frames are decoded from tx at mid-bit.
module tb_buffer_uart_tx;

  localparam int C  = 4;
  localparam int NB = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_read;
  logic        tx;
  logic        busy;
  logic [15:0] words_sent;

  always #5 clk = ~clk;

  buffer_uart_tx #(
    .DATA_WIDTH  (32),
    .CLKS_PER_BIT(C),
    .CNT_W       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_read (word_read),
    .tx        (tx),
    .busy      (busy),
    .words_sent(words_sent)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rd_count = 0;
  int   consec = 0;
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_read === 1'b1) rd_count <= rd_count + 1;
    if (word_read === 1'b1 && prev_rd === 1'b1) consec <= consec + 1;
    prev_rd <= word_read;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]        word;
    logic [0:3][7:0]    bytes;
    logic [0:3]         par;
    logic [15:0]        ws;
  } vec_t;

  vec_t vecs[3];

  task automatic wait_read(input string tag);
    bit f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_read === 1'b1) begin
        f = 1'b1;
        break;
      end
    end
    check({tag, " word_read_seen"}, 32'(f), 32'd1);
  endtask

  // Decodes NB back-to-back frames starting at the first low on tx, then checks the word end.
  task automatic decode_word(input logic [0:3][7:0] eb, input logic [0:3] ep,
                             input logic [15:0] ews, input string tag, output int s_cyc);
    bit found = 1'b0;
    s_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " start_seen"}, 32'(found), 32'd1);
    if (!found) return;
    s_cyc = cyc;
    repeat (C / 2) @(negedge clk);
    for (int j = 0; j < NB; j++) begin
      logic [7:0] rx;
      logic       p;
      rx = '0;
      p  = 1'b0;
      for (int k = 0; k < FB; k++) begin
        if (!(j == 0 && k == 0)) repeat (C) @(negedge clk);
        if (k == 0)           check($sformatf("%s byte%0d start", tag, j), 32'(tx), 32'd0);
        else if (k <= 8)      rx[k-1] = tx;
        else if (k == FB - 1) check($sformatf("%s byte%0d stop", tag, j), 32'(tx), 32'd1);
        else                  p = tx;
      end
      check($sformatf("%s byte%0d data", tag, j), 32'(rx), 32'(eb[j]));
`ifdef UART_PARITY_EN
      check($sformatf("%s byte%0d parity", tag, j), 32'(p), 32'(ep[j]));
`else
      if (p !== 1'b0 || ep === 4'bxxxx) check({tag, " no_parity_slot"}, 32'(p), 32'd0);
`endif
    end
    repeat (C / 2 - 1) @(negedge clk);
    check({tag, " busy_last_stop"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " tx_after"}, 32'(tx), 32'd1);
    check({tag, " words_sent"}, 32'(words_sent), 32'(ews));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int s1;
    int s2;
    bit found;

    vecs[0] = '{word: 32'hA1B2C3D4, bytes: {8'hA1, 8'hB2, 8'hC3, 8'hD4}, par: 4'b1000, ws: 16'd1};
    vecs[1] = '{word: 32'h07000000, bytes: {8'h07, 8'h00, 8'h00, 8'h00}, par: 4'b1000, ws: 16'd2};
    vecs[2] = '{word: 32'h80FE017F, bytes: {8'h80, 8'hFE, 8'h01, 8'h7F}, par: 4'b1111, ws: 16'd3};

    // Reset held with a word offered: nothing may move.
    rst        = 1'b0;
    word_valid = 1'b1;
    word_in    = 32'hDEADBEEF;
    repeat (6) begin
      @(negedge clk);
      check("reset tx", 32'(tx), 32'd1);
      check("reset word_read", 32'(word_read), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset words_sent", 32'(words_sent), 32'd0);
    end
    word_valid = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rd_count", 32'(rd_count), 32'd0);
    check("idle tx", 32'(tx), 32'd1);

    // Single words from the table; word_in is scrambled after capture.
    for (int i = 0; i < 3; i++) begin
      base       = rd_count;
      word_in    = vecs[i].word;
      word_valid = 1'b1;
      wait_read($sformatf("vec%0d", i));
      word_valid = 1'b0;
      word_in    = ~vecs[i].word;
      decode_word(vecs[i].bytes, vecs[i].par, vecs[i].ws, $sformatf("vec%0d", i), s1);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d read_pulses", i), 32'(rd_count - base), 32'd1);
    end

    // Back-to-back words with word_valid held high.
    base       = rd_count;
    word_in    = 32'h00000000;
    word_valid = 1'b1;
    wait_read("b2b1");
    word_in = 32'hFFFFFFFF;
    decode_word({8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000, 16'd4, "b2b1", s1);
    @(negedge clk);
    check("b2b2 word_read", 32'(word_read), 32'd1);
    word_valid = 1'b0;
    decode_word({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000, 16'd5, "b2b2", s2);
    check("b2b gap_cycles", 32'(s2 - s1 - NB * FB * C), 32'd3);
    repeat (3) @(negedge clk);
    check("b2b read_pulses", 32'(rd_count - base), 32'd2);

    // Stale valid: word_valid lingers through FETCH and GUARD, then the buffer is empty.
    base       = rd_count;
    word_in    = 32'h5A3C0F81;
    word_valid = 1'b1;
    wait_read("stale");
    repeat (2) @(negedge clk);
    word_valid = 1'b0;
    decode_word({8'h5A, 8'h3C, 8'h0F, 8'h81}, 4'b0000, 16'd6, "stale", s1);
    repeat (6) @(negedge clk);
    check("stale read_pulses", 32'(rd_count - base), 32'd1);
    check("stale busy_idle", 32'(busy), 32'd0);
    check("stale tx_idle", 32'(tx), 32'd1);

    // Reset during DATA bit 3 of byte 1 (0xB2, bit 3 = 0).
    word_in    = 32'hA1B2C3D4;
    word_valid = 1'b1;
    wait_read("midrst");
    word_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midrst start_seen", 32'(found), 32'd1);
    repeat (FB * C + 4 * C + C / 2) @(negedge clk);
    check("midrst tx_before", 32'(tx), 32'd0);
    check("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst word_read", 32'(word_read), 32'd0);
    check("midrst words_sent", 32'(words_sent), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst tx_hold", 32'(tx), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst tx_released", 32'(tx), 32'd1);
    word_in    = vecs[0].word;
    word_valid = 1'b1;
    wait_read("after_rst");
    word_valid = 1'b0;
    decode_word(vecs[0].bytes, vecs[0].par, 16'd1, "after_rst", s1);

    repeat (2) @(negedge clk);
    check("word_read never consecutive", 32'(consec), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
